// File: rtl/mem_l15_initiator_pkg.sv
// mem_l15_initiator_pkg: L1.5 request/return encodings, field widths and initiator FSM states.
package mem_l15_initiator_pkg;
    localparam logic [4:0] LOAD_RQ  = 5'b00000;
    localparam logic [4:0] STORE_RQ = 5'b00001;
    localparam logic [3:0] LOAD_RET = 4'h0;
    localparam logic [3:0] ST_ACK   = 4'h4;
    localparam int L15_THREADID_WIDTH = 1;
    localparam int L15_AMO_OP_WIDTH   = 4;
    localparam int L15_CMO_OP_WIDTH   = 6;
    localparam int TLB_CSM_WIDTH      = 33;
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RSP} state_t;
    // Sizes above 8B are treated as needing 8B alignment.
    function automatic logic misaligned(input logic [2:0] a, input logic [2:0] s);
        return (s == 3'd0) ? 1'b0 : (s == 3'd1) ? a[0] : (s == 3'd2) ? |a[1:0] : |a[2:0];
    endfunction
endpackage

// File: rtl/mem_l15_initiator.sv
// mem_l15_initiator: turns single core load/store requests into non-cacheable L1.5 transactions,
// with misalignment rejection and a response timeout that drops the late reply.
module mem_l15_initiator
    import mem_l15_initiator_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int THREAD_ID      = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_val,
    output logic                          req_rdy,
    input  logic                          req_we,
    input  logic [39:0]                   req_addr,
    input  logic [2:0]                    req_size,
    input  logic [63:0]                   req_wdata,
    output logic                          rsp_val,
    input  logic                          rsp_rdy,
    output logic [63:0]                   rsp_rdata,
    output logic [1:0]                    rsp_err,
    output logic                          transducer_l15_val,
    output logic [4:0]                    transducer_l15_rqtype,
    output logic                          transducer_l15_nc,
    output logic [2:0]                    transducer_l15_size,
    output logic [39:0]                   transducer_l15_address,
    output logic [63:0]                   transducer_l15_data,
    output logic [63:0]                   transducer_l15_data_next_entry,
    output logic [L15_THREADID_WIDTH-1:0] transducer_l15_threadid,
    output logic [L15_AMO_OP_WIDTH-1:0]   transducer_l15_amo_op,
    output logic [L15_CMO_OP_WIDTH-1:0]   transducer_l15_cmo_op,
    output logic [TLB_CSM_WIDTH-1:0]      transducer_l15_csm_data,
    output logic                          transducer_l15_prefetch,
    output logic                          transducer_l15_invalidate_cacheline,
    output logic                          transducer_l15_blockstore,
    output logic                          transducer_l15_blockinitstore,
    output logic [1:0]                    transducer_l15_l1rplway,
    input  logic                          l15_transducer_ack,
    input  logic                          l15_transducer_header_ack,
    input  logic                          l15_transducer_val,
    input  logic [3:0]                    l15_transducer_returntype,
    input  logic [1:0]                    l15_transducer_error,
    input  logic [63:0]                   l15_transducer_data_0,
    output logic                          transducer_l15_req_ack
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    state_t          r_state, w_next;
    logic            r_we, r_stale;
    logic [39:0]     r_addr;
    logic [2:0]      r_size;
    logic [63:0]     r_wdata;
    logic [CW-1:0]   r_cnt;
    logic            w_accept, w_misal, w_ret, w_match, w_timeout, w_unused;

    assign w_unused  = l15_transducer_header_ack;
    assign req_rdy   = (r_state == S_IDLE) && !r_stale && !rst;
    assign w_accept  = req_val && req_rdy;
    assign w_misal   = misaligned(req_addr[2:0], req_size);
    assign w_ret     = l15_transducer_val &&
                       (l15_transducer_returntype == LOAD_RET || l15_transducer_returntype == ST_ACK);
    assign w_match   = l15_transducer_val && !r_stale &&
                       (l15_transducer_returntype == (r_we ? ST_ACK : LOAD_RET));
    assign w_timeout = r_cnt == CW'(TIMEOUT_CYCLES - 1);

    assign rsp_val                             = r_state == S_RSP;
    assign transducer_l15_req_ack              = l15_transducer_val;
    assign transducer_l15_val                  = r_state == S_REQ;
    assign transducer_l15_rqtype               = r_we ? STORE_RQ : LOAD_RQ;
    assign transducer_l15_nc                   = 1'b1;
    assign transducer_l15_size                 = r_size;
    assign transducer_l15_address              = r_addr;
    assign transducer_l15_data                 = r_wdata;
    assign transducer_l15_data_next_entry      = '0;
    assign transducer_l15_threadid             = L15_THREADID_WIDTH'(THREAD_ID);
    assign transducer_l15_amo_op               = '0;
    assign transducer_l15_cmo_op               = '0;
    assign transducer_l15_csm_data             = '0;
    assign transducer_l15_prefetch             = 1'b0;
    assign transducer_l15_invalidate_cacheline = 1'b0;
    assign transducer_l15_blockstore           = 1'b0;
    assign transducer_l15_blockinitstore       = 1'b0;
    assign transducer_l15_l1rplway             = '0;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_accept ? (w_misal ? S_RSP : S_REQ) : S_IDLE;
            S_REQ:   w_next = l15_transducer_ack ? S_WAIT : S_REQ;
            S_WAIT:  w_next = (w_match || w_timeout) ? S_RSP : S_WAIT;
            default: w_next = rsp_rdy ? S_IDLE : S_RSP;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_size    <= '0;
            r_wdata   <= '0;
            r_cnt     <= '0;
            r_stale   <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= '0;
        end else begin
            r_cnt <= (r_state == S_WAIT && w_next == S_WAIT) ? r_cnt + 1'b1 : '0;
            if (w_accept) begin
                r_we      <= req_we;
                r_addr    <= req_addr;
                r_size    <= req_size;
                r_wdata   <= req_wdata;
                rsp_rdata <= '0;
                rsp_err   <= w_misal ? 2'd1 : 2'd0;
            end
            // A match in the timeout cycle takes priority over the timeout.
            if (r_state == S_WAIT && w_match) begin
                rsp_rdata <= r_we ? 64'd0 : l15_transducer_data_0;
                rsp_err   <= (l15_transducer_error != 2'd0) ? 2'd3 : 2'd0;
            end else if (r_state == S_WAIT && w_timeout) begin
                rsp_rdata <= '0;
                rsp_err   <= 2'd2;
                r_stale   <= 1'b1;
            end
            if (r_stale && w_ret) r_stale <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mem_l15_initiator.sv
// tb_mem_l15_initiator: directed checks of the L1.5 initiator with a 16-cycle timeout.
module tb_mem_l15_initiator;
    import mem_l15_initiator_pkg::*;

    logic clk = 1'b0, rst = 1'b1;
    logic req_val = 0, req_we = 0, rsp_rdy = 0;
    logic [39:0] req_addr = '0;
    logic [2:0] req_size = '0;
    logic [63:0] req_wdata = '0;
    logic req_rdy, rsp_val;
    logic [63:0] rsp_rdata;
    logic [1:0] rsp_err;
    logic t_val, t_nc, t_pf, t_inv, t_bs, t_bis;
    logic [4:0] t_rqtype;
    logic [2:0] t_size;
    logic [39:0] t_addr;
    logic [63:0] t_data, t_dne;
    logic [L15_THREADID_WIDTH-1:0] t_tid;
    logic [L15_AMO_OP_WIDTH-1:0] t_amo;
    logic [L15_CMO_OP_WIDTH-1:0] t_cmo;
    logic [TLB_CSM_WIDTH-1:0] t_csm;
    logic [1:0] t_rpl;
    logic l15_ack = 0, l15_hack = 0, l15_val = 0;
    logic [3:0] l15_rt = '0;
    logic [1:0] l15_err = '0;
    logic [63:0] l15_d0 = '0;
    logic req_ack;
    int checks = 0, errors = 0;

    mem_l15_initiator #(.TIMEOUT_CYCLES(16), .THREAD_ID(0)) dut (
        .clk(clk), .rst(rst),
        .req_val(req_val), .req_rdy(req_rdy), .req_we(req_we), .req_addr(req_addr),
        .req_size(req_size), .req_wdata(req_wdata),
        .rsp_val(rsp_val), .rsp_rdy(rsp_rdy), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .transducer_l15_val(t_val), .transducer_l15_rqtype(t_rqtype), .transducer_l15_nc(t_nc),
        .transducer_l15_size(t_size), .transducer_l15_address(t_addr), .transducer_l15_data(t_data),
        .transducer_l15_data_next_entry(t_dne), .transducer_l15_threadid(t_tid),
        .transducer_l15_amo_op(t_amo), .transducer_l15_cmo_op(t_cmo), .transducer_l15_csm_data(t_csm),
        .transducer_l15_prefetch(t_pf), .transducer_l15_invalidate_cacheline(t_inv),
        .transducer_l15_blockstore(t_bs), .transducer_l15_blockinitstore(t_bis),
        .transducer_l15_l1rplway(t_rpl),
        .l15_transducer_ack(l15_ack), .l15_transducer_header_ack(l15_hack),
        .l15_transducer_val(l15_val), .l15_transducer_returntype(l15_rt),
        .l15_transducer_error(l15_err), .l15_transducer_data_0(l15_d0),
        .transducer_l15_req_ack(req_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic issue(input logic we, input logic [39:0] a, input logic [2:0] s, input logic [63:0] d);
        req_val = 1; req_we = we; req_addr = a; req_size = s; req_wdata = d;
        step();
        req_val = 0;
    endtask

    task automatic ack_now();
        l15_ack = 1;
        step();
        l15_ack = 0;
    endtask

    task automatic ret(input string tag, input logic [3:0] rt, input logic [63:0] d, input logic [1:0] e);
        l15_val = 1; l15_rt = rt; l15_d0 = d; l15_err = e;
        #1 chk({tag, "_req_ack"}, 64'(req_ack), 64'd1);
        step();
        l15_val = 0;
    endtask

    task automatic finish_rsp();
        rsp_rdy = 1;
        step();
        rsp_rdy = 0;
    endtask

    initial begin
        step();
        chk("rst_req_rdy", 64'(req_rdy), 64'd0);
        chk("rst_rsp_val", 64'(rsp_val), 64'd0);
        chk("rst_l15_val", 64'(t_val), 64'd0);
        chk("rst_rdata", rsp_rdata, 64'd0);
        rst = 0;
        #1 chk("idle_req_rdy", 64'(req_rdy), 64'd1);
        step();
        // Load with ack after two cycles
        issue(0, 40'h80_0000_0008, 3'd3, 64'd0);
        chk("ld_val", 64'(t_val), 64'd1);
        chk("ld_rqtype", 64'(t_rqtype), 64'(LOAD_RQ));
        chk("ld_nc", 64'(t_nc), 64'd1);
        chk("ld_addr", 64'(t_addr), 64'h80_0000_0008);
        chk("ld_size", 64'(t_size), 64'd3);
        chk("ld_dne", t_dne, 64'd0);
        chk("ld_unused", 64'({t_amo, t_cmo, t_csm, t_pf, t_inv, t_bs, t_bis, t_rpl, t_tid}), 64'd0);
        chk("ld_req_rdy", 64'(req_rdy), 64'd0);
        step();
        chk("ld_val_hold", 64'(t_val), 64'd1);
        chk("ld_addr_hold", 64'(t_addr), 64'h80_0000_0008);
        ack_now();
        chk("ld_val_drop", 64'(t_val), 64'd0);
        ret("ld", LOAD_RET, 64'hDEAD_BEEF_0123_4567, 2'd0);
        chk("ld_rsp_val", 64'(rsp_val), 64'd1);
        chk("ld_rdata", rsp_rdata, 64'hDEAD_BEEF_0123_4567);
        chk("ld_err", 64'(rsp_err), 64'd0);
        finish_rsp();
        chk("ld_done", 64'(rsp_val), 64'd0);
        chk("ld_rdy_back", 64'(req_rdy), 64'd1);
        // Store held until ack
        issue(1, 40'h10, 3'd2, 64'h1234);
        chk("st_rqtype", 64'(t_rqtype), 64'(STORE_RQ));
        chk("st_data", t_data, 64'h1234);
        step();
        step();
        chk("st_val_hold", 64'(t_val), 64'd1);
        chk("st_data_hold", t_data, 64'h1234);
        ack_now();
        ret("st", ST_ACK, 64'hFFFF_FFFF_FFFF_FFFF, 2'd0);
        chk("st_rsp_val", 64'(rsp_val), 64'd1);
        chk("st_err", 64'(rsp_err), 64'd0);
        chk("st_rdata", rsp_rdata, 64'd0);
        finish_rsp();
        // Misaligned
        issue(0, 40'h3, 3'd1, 64'd0);
        chk("mis_l15_val", 64'(t_val), 64'd0);
        chk("mis_rsp_val", 64'(rsp_val), 64'd1);
        chk("mis_err", 64'(rsp_err), 64'd1);
        chk("mis_rdata", rsp_rdata, 64'd0);
        finish_rsp();
        // Timeout after 16 WAIT cycles
        issue(0, 40'h20, 3'd3, 64'd0);
        ack_now();
        repeat (15) step();
        chk("to_not_yet", 64'(rsp_val), 64'd0);
        step();
        chk("to_rsp_val", 64'(rsp_val), 64'd1);
        chk("to_err", 64'(rsp_err), 64'd2);
        chk("to_rdata", rsp_rdata, 64'd0);
        finish_rsp();
        chk("stale_rdy", 64'(req_rdy), 64'd0);
        ret("late", LOAD_RET, 64'h1111, 2'd0);
        chk("late_rsp_val", 64'(rsp_val), 64'd0);
        chk("late_rdy", 64'(req_rdy), 64'd1);
        // Normal request after stale clears, with L1.5 error
        issue(0, 40'h40, 3'd3, 64'd0);
        ack_now();
        ret("l15e", LOAD_RET, 64'h0BAD_F00D, 2'd1);
        chk("l15e_rdata", rsp_rdata, 64'h0BAD_F00D);
        chk("l15e_err", 64'(rsp_err), 64'd3);
        finish_rsp();
        // Match in the timeout cycle wins
        issue(0, 40'h48, 3'd3, 64'd0);
        ack_now();
        repeat (15) step();
        ret("race", LOAD_RET, 64'h77, 2'd0);
        chk("race_err", 64'(rsp_err), 64'd0);
        chk("race_rdata", rsp_rdata, 64'h77);
        finish_rsp();
        chk("race_no_stale", 64'(req_rdy), 64'd1);
        // Eviction in WAIT is ignored, then backpressure
        issue(0, 40'h80, 3'd3, 64'd0);
        ack_now();
        ret("evict", 4'h3, 64'h9999, 2'd0);
        chk("evict_rsp_val", 64'(rsp_val), 64'd0);
        ret("int", 4'h7, 64'h8888, 2'd0);
        chk("int_rsp_val", 64'(rsp_val), 64'd0);
        ret("ev_ld", LOAD_RET, 64'h55, 2'd0);
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_val", 64'(rsp_val), 64'd1);
            chk("bp_rdata", rsp_rdata, 64'h55);
            chk("bp_err", 64'(rsp_err), 64'd0);
            step();
        end
        finish_rsp();
        chk("bp_done", 64'(rsp_val), 64'd0);
        // Reset while in REQ
        issue(0, 40'h100, 3'd3, 64'd0);
        chk("rr_val", 64'(t_val), 64'd1);
        rst = 1;
        #1 chk("rr_val_async", 64'(t_val), 64'd0);
        chk("rr_addr", 64'(t_addr), 64'd0);
        chk("rr_req_rdy", 64'(req_rdy), 64'd0);
        step();
        rst = 0;
        ret("rr_inflight", LOAD_RET, 64'h4242, 2'd0);
        chk("rr_rsp_val", 64'(rsp_val), 64'd0);
        chk("rr_rdy", 64'(req_rdy), 64'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
